sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter: n, 8, instruction width; bits [n-1:n-4] are the opcode and bits [3:0] are the operand.
REQ-002 Clock  input  1  the single clock; all state changes on the rising edge.
REQ-003 nReset  input  1  reset, synchronous, active-low.
REQ-004 MemData  input  n  instruction word for the current Pc.
REQ-005 AccZero  input  1  high when the accumulator is zero.
REQ-006 SwValid  input  1  switch data valid (request).
REQ-007 SwAck  output  1  switch data consumed, one-cycle pulse.
REQ-008 RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe  output  1 each  datapath controls.
REQ-009 AluOp  output  opcodes::alu_functions_t  ALU function select.
REQ-010 PcSel  output  opcodes::PcSel_t  Pc source, PcInc or PcJmp.
REQ-011 Halted  output  1  high while in HALT.
REQ-012 IllegalOp  output  1  sticky flag, set on an undefined opcode.

Function
REQ-013 FSM states: FETCH, EXEC, WAIT_SW, HALT.
- FETCH always goes to EXEC.
- EXEC goes to FETCH, to WAIT_SW (IN with SwValid=0), or to HALT (opcode 0xF).
REQ-014 FETCH drives every write enable low (RegWe, AccWe, PcWe), giving MemData one cycle to settle.
REQ-015 EXEC decodes MemData and drives the controls for one cycle; each instruction therefore takes 2 cycles, except IN when it waits.
REQ-016 Every completing EXEC asserts PcWe; PcSel=PcInc unless a jump is taken.
REQ-017 Opcodes: 0x0 NOP asserts PcWe only.
REQ-018 Opcodes: 0x1 LDI.
- Op1Sel=1, ImmSel=0, AluOp=pass-A, AccWe=1.
- 0x2 LUI is the same with ImmSel=1.
REQ-019 Opcodes: 0x3 LD r uses Op1Sel=0, AluOp=pass-A, AccWe=1.
REQ-020 Opcodes: 0x4 ST r uses RegWe=1, WDataSel=0.
REQ-021 Opcodes: 0x5 ADD, 0x6 SUB, 0x7 AND, 0x8 OR r.
- Op1Sel=0, AluOp set to the matching function, AccWe=1.
- 0x9 ADDI uses Op1Sel=1, ImmSel=0, AluOp=add.
REQ-022 Opcodes: 0xA IN r, when SwValid=1 in EXEC or WAIT_SW:
- RegWe=1, WDataSel=1, SwAck=1, PcWe=1, then the FSM goes to FETCH.
- While SwValid=0, RegWe, PcWe and SwAck stay 0 and the FSM holds in WAIT_SW.
REQ-023 Opcodes: 0xB JMP r uses Op1Sel=0, AluOp=pass-A, PcSel=PcJmp, PcWe=1, AccWe=0.
REQ-024 Opcodes: 0xC BZ r.
- Behaves as JMP when AccZero=1.
- Otherwise PcSel=PcInc.
REQ-025 Opcodes: 0xF HALT.
- Pc is not advanced.
- The FSM enters HALT, asserts Halted, and holds with all enables 0 until reset.
REQ-026 Opcodes: 0xD and 0xE are treated as NOP and set IllegalOp, which stays set until reset.
REQ-027 SwAck is never asserted outside an IN completion; SwValid is ignored in all other states.
REQ-028 Outputs are combinational from the state and the registered inputs (Moore plus decode); AluOp defaults to pass-A when unused.

Reset
REQ-029 When nReset=0 at a rising edge, the next state is FETCH, IllegalOp=0, and the step latch is cleared, regardless of the current state (including WAIT_SW and HALT).
REQ-030 During and immediately after reset: all enables=0, SwAck=0, Halted=0, PcSel=PcInc.

Configuration
REQ-031 Macro SEQ_STEP_EN: when defined, the module adds inputs StepMode (1 bit) and Step (1 bit).
- With StepMode=1, FETCH waits until a rising edge of Step, detected by a registered edge, before entering EXEC.
- A Step held high executes exactly one instruction.
- Without the macro, these ports and this logic are absent and FETCH always advances.

Structure
REQ-032 Package opcodes holds:
- the opcode enum (4-bit, values listed in REQ-017 to REQ-026);
- the state enum seq_state_t;
- alu_functions_t and PcSel_t.
REQ-033 The instruction decode is a separate combinational sub-module, decoder, which maps opcode and AccZero to the control bundle; sequencer holds the FSM, the IllegalOp register and the step logic.

Verification
REQ-034 Reset, then MemData=0x17 -> FETCH then EXEC; in EXEC: AccWe=1, Op1Sel=1, ImmSel=0, PcWe=1, PcSel=PcInc.
REQ-035 MemData=0xA3, SwValid low for 5 cycles then high -> RegWe, PcWe and SwAck stay 0 for 5 cycles; then exactly one cycle with RegWe=1, WDataSel=1, SwAck=1; then FETCH.
REQ-036 MemData=0xC2 with AccZero=1 -> PcSel=PcJmp, PcWe=1; with AccZero=0 -> PcSel=PcInc.
REQ-037 MemData=0xF0 -> Halted=1 from the next cycle, all enables 0 for 20 cycles; nReset=0 for one edge -> Halted=0, state FETCH.
REQ-038 MemData=0xD5 -> IllegalOp=1 and stays set through later valid instructions until reset; PcWe=1 in that EXEC.
REQ-039 With SEQ_STEP_EN and StepMode=1 -> no EXEC until a Step pulse; a Step held high for 10 cycles yields exactly one PcWe.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared types for the sequencer: opcodes, FSM states, ALU function select,
// Pc source select and the decoded control bundle.
package opcodes;

    localparam int unsigned OPC_W = 4;

    // Instruction opcodes (upper nibble of the instruction word)
    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LUI  = 4'h2,
        OP_LD   = 4'h3,
        OP_ST   = 4'h4,
        OP_ADD  = 4'h5,
        OP_SUB  = 4'h6,
        OP_AND  = 4'h7,
        OP_OR   = 4'h8,
        OP_ADDI = 4'h9,
        OP_IN   = 4'hA,
        OP_JMP  = 4'hB,
        OP_BZ   = 4'hC,
        OP_ILLD = 4'hD,
        OP_ILLE = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WAIT_SW,
        HALT
    } seq_state_t;

    typedef enum logic [2:0] {
        ALU_PASS_A,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_functions_t;

    typedef enum logic {
        PcInc,
        PcJmp
    } PcSel_t;

    // Control bundle produced by the decoder for one EXEC cycle
    typedef struct packed {
        logic           reg_we;
        logic           imm_sel;
        logic           wdata_sel;
        logic           acc_we;
        logic           op1_sel;
        logic           pc_we;
        alu_functions_t alu_op;
        PcSel_t         pc_sel;
        logic           is_in;
        logic           is_halt;
        logic           illegal;
    } ctrl_t;

endpackage

// File: rtl/sequencer_decoder.sv
// Purely combinational instruction decode: opcode + AccZero -> control bundle.
// IN is decoded with its full write controls; the sequencer gates them on SwValid.
module decoder
    import opcodes::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic             acc_zero,
    output ctrl_t            ctrl
);

    // Map each opcode to its datapath controls; unused ALU defaults to pass-A
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_PASS_A;
        ctrl.pc_sel = PcInc;
        case (opcode_t'(opcode))
            OP_NOP: ctrl.pc_we = 1'b1;
            OP_LDI: begin
                ctrl.op1_sel = 1'b1;
                ctrl.acc_we  = 1'b1;
                ctrl.pc_we   = 1'b1;
            end
            OP_LUI: begin
                ctrl.op1_sel = 1'b1;
                ctrl.imm_sel = 1'b1;
                ctrl.acc_we  = 1'b1;
                ctrl.pc_we   = 1'b1;
            end
            OP_LD: begin
                ctrl.acc_we = 1'b1;
                ctrl.pc_we  = 1'b1;
            end
            OP_ST: begin
                ctrl.reg_we = 1'b1;
                ctrl.pc_we  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                ctrl.acc_we = 1'b1;
                ctrl.pc_we  = 1'b1;
                case (opcode_t'(opcode))
                    OP_ADD:  ctrl.alu_op = ALU_ADD;
                    OP_SUB:  ctrl.alu_op = ALU_SUB;
                    OP_AND:  ctrl.alu_op = ALU_AND;
                    default: ctrl.alu_op = ALU_OR;
                endcase
            end
            OP_ADDI: begin
                ctrl.op1_sel = 1'b1;
                ctrl.acc_we  = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                ctrl.pc_we   = 1'b1;
            end
            OP_IN: begin
                ctrl.is_in     = 1'b1;
                ctrl.reg_we    = 1'b1;
                ctrl.wdata_sel = 1'b1;
                ctrl.pc_we     = 1'b1;
            end
            OP_JMP: begin
                ctrl.pc_sel = PcJmp;
                ctrl.pc_we  = 1'b1;
            end
            OP_BZ: begin
                ctrl.pc_sel = acc_zero ? PcJmp : PcInc;
                ctrl.pc_we  = 1'b1;
            end
            OP_ILLD, OP_ILLE: begin
                ctrl.illegal = 1'b1;
                ctrl.pc_we   = 1'b1;
            end
            OP_HALT: ctrl.is_halt = 1'b1;
            default: ctrl.pc_we = 1'b1;
        endcase
    end

endmodule

// File: rtl/sequencer.sv
// Instruction sequencer: FETCH/EXEC/WAIT_SW/HALT FSM, sticky IllegalOp flag
// and optional single-step gating of FETCH (enabled by macro SEQ_STEP_EN).
module sequencer
    import opcodes::*;
#(
    parameter int n = 8
) (
    input  logic           Clock,
    input  logic           nReset,
`ifdef SEQ_STEP_EN
    input  logic           StepMode,
    input  logic           Step,
`endif
    input  logic [n-1:0]   MemData,
    input  logic           AccZero,
    input  logic           SwValid,
    output logic           SwAck,
    output logic           RegWe,
    output logic           ImmSel,
    output logic           WDataSel,
    output logic           AccWe,
    output logic           Op1Sel,
    output logic           PcWe,
    output alu_functions_t AluOp,
    output PcSel_t         PcSel,
    output logic           Halted,
    output logic           IllegalOp
);

    seq_state_t state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       fetch_go;
    ctrl_t      ctrl;

    // Operand bits are consumed by the datapath, not by the sequencer
    logic unused_operand;
    assign unused_operand = ^MemData[n-5:0];

    decoder u_decoder (
        .opcode   (MemData[n-1:n-4]),
        .acc_zero (AccZero),
        .ctrl     (ctrl)
    );

`ifdef SEQ_STEP_EN
    logic step_prev_q, step_prev_d;
    logic step_pend_q, step_pend_d;

    // Latch a Step rising edge until FETCH consumes it; held Step gives one edge
    always_comb begin
        step_prev_d = Step;
        step_pend_d = (Step & ~step_prev_q) | (step_pend_q & (state_q != FETCH));
        fetch_go    = ~StepMode | step_pend_q;
    end

    // Step edge detector and pending-step latch
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_prev_q <= step_prev_d;
            step_pend_q <= step_pend_d;
        end
    end
`else
    assign fetch_go = 1'b1;
`endif

    // State and sticky illegal-opcode register
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and IllegalOp set logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q | ((state_q == EXEC) & ctrl.illegal);
        case (state_q)
            FETCH: begin
                if (fetch_go) state_d = EXEC;
            end
            EXEC: begin
                if (ctrl.is_halt)                state_d = HALT;
                else if (ctrl.is_in && !SwValid) state_d = WAIT_SW;
                else                             state_d = FETCH;
            end
            WAIT_SW: begin
                if (SwValid) state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Moore-plus-decode outputs; everything idle while reset is asserted
    always_comb begin
        RegWe    = 1'b0;
        ImmSel   = 1'b0;
        WDataSel = 1'b0;
        AccWe    = 1'b0;
        Op1Sel   = 1'b0;
        PcWe     = 1'b0;
        SwAck    = 1'b0;
        Halted   = 1'b0;
        AluOp    = ALU_PASS_A;
        PcSel    = PcInc;
        if (nReset) begin
            case (state_q)
                EXEC: begin
                    if (!ctrl.is_in || SwValid) begin
                        RegWe    = ctrl.reg_we;
                        ImmSel   = ctrl.imm_sel;
                        WDataSel = ctrl.wdata_sel;
                        AccWe    = ctrl.acc_we;
                        Op1Sel   = ctrl.op1_sel;
                        PcWe     = ctrl.pc_we;
                        AluOp    = ctrl.alu_op;
                        PcSel    = ctrl.pc_sel;
                        SwAck    = ctrl.is_in;
                    end
                end
                WAIT_SW: begin
                    if (SwValid) begin
                        RegWe    = 1'b1;
                        WDataSel = 1'b1;
                        PcWe     = 1'b1;
                        SwAck    = 1'b1;
                    end
                end
                HALT:    Halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for sequencer: an instruction-level model checked every
// cycle, plus directed literal checks. Step tests run when SEQ_STEP_EN is defined.
module tb_sequencer;
    import opcodes::*;

    logic           Clock = 1'b0;
    logic           nReset;
`ifdef SEQ_STEP_EN
    logic           StepMode;
    logic           Step;
`endif
    logic [7:0]     MemData;
    logic           AccZero;
    logic           SwValid;
    logic           SwAck, RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe;
    alu_functions_t AluOp;
    PcSel_t         PcSel;
    logic           Halted, IllegalOp;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    sequencer #(.n(8)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
`ifdef SEQ_STEP_EN
        .StepMode  (StepMode),
        .Step      (Step),
`endif
        .MemData   (MemData),
        .AccZero   (AccZero),
        .SwValid   (SwValid),
        .SwAck     (SwAck),
        .RegWe     (RegWe),
        .ImmSel    (ImmSel),
        .WDataSel  (WDataSel),
        .AccWe     (AccWe),
        .Op1Sel    (Op1Sel),
        .PcWe      (PcWe),
        .AluOp     (AluOp),
        .PcSel     (PcSel),
        .Halted    (Halted),
        .IllegalOp (IllegalOp)
    );

    always #5 Clock = ~Clock;

    // ---------------- instruction-level model ----------------
    // m_phase: 0 = fetching, 1 = executing (or waiting for switches)
    int unsigned m_phase = 0;
    bit m_wait = 0, m_halt = 0, m_ill = 0;
    bit m_credit = 0, m_step_prev = 0;

    always @(posedge Clock) begin
        bit [3:0] op;
        bit gated, rise;
        int unsigned old_phase;
        old_phase = m_phase;
        if (!nReset) begin
            m_phase = 0; m_wait = 0; m_halt = 0; m_ill = 0;
            m_credit = 0; m_step_prev = 0;
        end else begin
            gated = 0;
            rise  = 0;
`ifdef SEQ_STEP_EN
            gated = StepMode && !m_credit;
            rise  = Step && !m_step_prev;
            m_step_prev = Step;
`endif
            if (m_halt) begin
                // stays halted
            end else if (m_phase == 0) begin
                if (!gated) m_phase = 1;
            end else begin
                op = m_wait ? 4'hA : MemData[7:4];
                if (op == 4'hD || op == 4'hE) m_ill = 1;
                if (op == 4'hF) m_halt = 1;
                else if (op == 4'hA && !SwValid) m_wait = 1;
                else begin
                    m_phase = 0;
                    m_wait  = 0;
                end
            end
            m_credit = rise || (m_credit && old_phase != 0);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge Clock) begin
        bit [12:0] e_v, a_v;
        bit [3:0]  op;
        bit e_reg, e_imm, e_wd, e_acc, e_op1, e_pc, e_jmp, e_ack;
        bit [2:0] e_alu;
        if (check_en) begin
            {e_reg, e_imm, e_wd, e_acc, e_op1, e_pc, e_jmp, e_ack} = '0;
            e_alu = 3'(ALU_PASS_A);
            if (nReset && !m_halt && m_phase == 1) begin
                op = m_wait ? 4'hA : MemData[7:4];
                case (op)
                    4'h1: begin e_op1 = 1; e_acc = 1; e_pc = 1; end
                    4'h2: begin e_op1 = 1; e_imm = 1; e_acc = 1; e_pc = 1; end
                    4'h3: begin e_acc = 1; e_pc = 1; end
                    4'h4: begin e_reg = 1; e_pc = 1; end
                    4'h5: begin e_acc = 1; e_pc = 1; e_alu = 3'(ALU_ADD); end
                    4'h6: begin e_acc = 1; e_pc = 1; e_alu = 3'(ALU_SUB); end
                    4'h7: begin e_acc = 1; e_pc = 1; e_alu = 3'(ALU_AND); end
                    4'h8: begin e_acc = 1; e_pc = 1; e_alu = 3'(ALU_OR); end
                    4'h9: begin e_op1 = 1; e_acc = 1; e_pc = 1; e_alu = 3'(ALU_ADD); end
                    4'hA: if (SwValid) begin e_reg = 1; e_wd = 1; e_ack = 1; e_pc = 1; end
                    4'hB: begin e_jmp = 1; e_pc = 1; end
                    4'hC: begin e_jmp = AccZero; e_pc = 1; end
                    4'hF: ;
                    default: e_pc = 1;
                endcase
            end
            e_v = {e_reg, e_imm, e_wd, e_acc, e_op1, e_pc, e_jmp, e_ack,
                   m_halt && nReset, m_ill, e_alu};
            a_v = {RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe, PcSel == PcJmp,
                   SwAck, Halted, IllegalOp, 3'(AluOp)};
            tests++;
            if (a_v !== e_v) begin
                fails++;
                $display("FAIL model_cycle t=%0t: got %b required %b (reg,imm,wd,acc,op1,pc,jmp,ack,halt,ill,alu)",
                         $time, a_v, e_v);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Runs one non-waiting instruction from FETCH back to FETCH
    task automatic run_instr(input logic [7:0] instr, input logic az, input logic sv);
        MemData = instr; AccZero = az; SwValid = sv;
        tick();
        tick();
        $display("[TB] instr %02h acc_zero=%0d sw_valid=%0d", instr, az, sv);
    endtask

    logic [7:0] prog [13] = '{8'h00, 8'h15, 8'h25, 8'h33, 8'h44, 8'h56, 8'h67,
                              8'h78, 8'h89, 8'h9A, 8'hA7, 8'hB1, 8'hC3};

    initial begin
        int cnt;
        nReset = 1'b0; MemData = 8'h00; AccZero = 1'b0; SwValid = 1'b0;
`ifdef SEQ_STEP_EN
        StepMode = 1'b0; Step = 1'b0;
`endif
        tick();
        check_en = 1'b1;
        @(negedge Clock);
        check("reset_pcwe", int'(PcWe), 0);
        check("reset_halted", int'(Halted), 0);
        check("reset_illegal", int'(IllegalOp), 0);
        tick();
        nReset = 1'b1;

        // LDI: FETCH then EXEC
        MemData = 8'h17;
        @(negedge Clock);
        check("ldi_fetch_pcwe", int'(PcWe), 0);
        check("ldi_fetch_accwe", int'(AccWe), 0);
        tick();
        @(negedge Clock);
        check("ldi_exec_accwe", int'(AccWe), 1);
        check("ldi_exec_op1sel", int'(Op1Sel), 1);
        check("ldi_exec_immsel", int'(ImmSel), 0);
        check("ldi_exec_pcwe", int'(PcWe), 1);
        check("ldi_exec_pcsel", int'(PcSel), int'(PcInc));
        tick();
        $display("[TB] instr 17 ldi");

        // IN with switches not ready for 5 cycles
        MemData = 8'hA3; SwValid = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            cnt += int'(RegWe) + int'(PcWe) + int'(SwAck);
            tick();
        end
        check("in_wait_idle", cnt, 0);
        SwValid = 1'b1;
        @(negedge Clock);
        check("in_done_regwe", int'(RegWe), 1);
        check("in_done_wdsel", int'(WDataSel), 1);
        check("in_done_swack", int'(SwAck), 1);
        tick();
        SwValid = 1'b0;
        MemData = 8'h00;
        @(negedge Clock);
        check("in_after_swack", int'(SwAck), 0);
        tick();
        tick();
        $display("[TB] instr a3 in with 5-cycle wait");

        // BZ taken / not taken
        MemData = 8'hC2; AccZero = 1'b1;
        tick();
        @(negedge Clock);
        check("bz_taken_pcsel", int'(PcSel), int'(PcJmp));
        check("bz_taken_pcwe", int'(PcWe), 1);
        tick();
        AccZero = 1'b0;
        tick();
        @(negedge Clock);
        check("bz_not_taken_pcsel", int'(PcSel), int'(PcInc));
        tick();
        $display("[TB] instr c2 bz both ways");

        // Undefined opcode sets a sticky flag
        MemData = 8'hD5;
        tick();
        @(negedge Clock);
        check("illegal_exec_pcwe", int'(PcWe), 1);
        tick();
        @(negedge Clock);
        check("illegal_set", int'(IllegalOp), 1);
        for (int i = 0; i < 13; i++) run_instr(prog[i], 1'(i % 2), 1'b1);
        @(negedge Clock);
        check("illegal_sticky", int'(IllegalOp), 1);

        // HALT holds with everything idle, even with SwValid asserted
        MemData = 8'hF0;
        tick();
        @(negedge Clock);
        check("halt_exec_pcwe", int'(PcWe), 0);
        tick();
        SwValid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            cnt += int'(Halted);
            cnt += 100 * (int'(RegWe) + int'(AccWe) + int'(PcWe) + int'(SwAck));
            tick();
        end
        check("halt_20_cycles", cnt, 20);
        SwValid = 1'b0;
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        MemData = 8'h00;
        @(negedge Clock);
        check("halt_reset_halted", int'(Halted), 0);
        check("halt_reset_illegal", int'(IllegalOp), 0);
        check("halt_reset_fetch", int'(PcWe), 0);
        tick();
        @(negedge Clock);
        check("halt_reset_exec", int'(PcWe), 1);
        tick();
        $display("[TB] instr f0 halt then reset");

        // Reset out of WAIT_SW
        MemData = 8'hA1; SwValid = 1'b0;
        tick(); tick(); tick();
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        SwValid = 1'b1;
        MemData = 8'h00;
        @(negedge Clock);
        check("waitsw_reset_fetch", int'(SwAck) + int'(PcWe), 0);
        tick();
        @(negedge Clock);
        check("waitsw_reset_exec", int'(PcWe), 1);
        tick();
        SwValid = 1'b0;
        $display("[TB] instr a1 reset while waiting");

`ifdef SEQ_STEP_EN
        // Single-step: nothing runs until Step rises; a held Step runs one instruction
        StepMode = 1'b1; Step = 1'b0;
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        MemData = 8'h00;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            cnt += int'(PcWe);
            tick();
        end
        check("step_none_without_pulse", cnt, 0);
        Step = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            cnt += int'(PcWe);
            tick();
        end
        check("step_held_one_pcwe", cnt, 1);
        Step = 1'b0;
        tick();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            cnt += int'(PcWe);
            tick();
        end
        check("step_pulse_one_pcwe", cnt, 1);
        StepMode = 1'b0;
        $display("[TB] step mode sequence");
`endif

        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule
